// File: rtl/reduction_pkg.sv
// Shared types and sizing for the reduction operand feeder.
package reduction_pkg;
  // Local stand-in for fpnew_pkg::fp_width(FP16), so this slice builds on its own.
  function automatic int fp16_width();
    return 16;
  endfunction

  localparam int TILE_SIZE     = 129;
  localparam int PARALLEL_SIZE = 3;
  localparam int WIDTH         = fp16_width();
  localparam int MAX_ROWS      = 1023;
  localparam int CW            = $clog2(MAX_ROWS + 1);
  localparam int PW            = $clog2(PARALLEL_SIZE);

  typedef logic [WIDTH-1:0]            lane_t;
  typedef lane_t [TILE_SIZE-1:0]       row_t;
  typedef row_t  [PARALLEL_SIZE-1:0]   group_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_DONE
  } feeder_state_e;

  localparam lane_t FP16_POS_ZERO = 16'h0000;
endpackage

// File: rtl/reduction_feeder_if.sv
// Row stream handshake into the feeder.
interface reduction_feeder_if;
  import reduction_pkg::*;
  logic row_valid;
  logic row_ready;
  row_t row;

  modport master (output row_valid, output row, input  row_ready);
  modport slave  (input  row_valid, input  row, output row_ready);
endinterface

// File: rtl/reduction_row_packer.sv
// Holds partially filled group slots; presents the padded group for the current row.
module reduction_row_packer
  import reduction_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_accept,
  input  logic          i_issue,
  input  row_t          i_row,
  output logic [PW-1:0] o_cnt,
  output group_t        o_group
);
  row_t [PARALLEL_SIZE-2:0] r_slot;
  logic [PW-1:0]            r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else if (i_accept) begin
      if (i_issue) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        for (int s = 0; s < PARALLEL_SIZE-1; s++)
          if (r_cnt == PW'(s)) r_slot[s] <= i_row;
      end
    end
  end

  // Slots below cnt are held rows, slot cnt is the incoming row, the rest pad with +0.
  for (genvar s = 0; s < PARALLEL_SIZE; s++) begin : g_slot
    if (s < PARALLEL_SIZE-1) begin : g_held
      assign o_group[s] = (PW'(s) < r_cnt)  ? r_slot[s] :
                          (PW'(s) == r_cnt) ? i_row     : {TILE_SIZE{FP16_POS_ZERO}};
    end else begin : g_top
      assign o_group[s] = (PW'(s) == r_cnt) ? i_row : {TILE_SIZE{FP16_POS_ZERO}};
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/reduction_feeder.sv
// Packs tile rows into groups and sequences seed load, accumulation and completion
// for the free-running tile reduction unit.
module reduction_feeder
  import reduction_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RST_ni,
  input  logic              start_i,
  input  logic [CW-1:0]     num_rows_i,
  input  row_t              seed_i,
  reduction_feeder_if.slave row_if,
  output group_t            operand_o,
  output row_t              set_reg_o,
  output logic              acc_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              result_valid_o
);
  feeder_state_e r_state;
  logic [CW-1:0] r_rem;
  row_t          r_seed;
  group_t        r_operand;
  logic          r_acc_rst, r_ready, r_busy, r_done, r_rv;

  group_t        w_group;
  logic [PW-1:0] w_cnt;
  logic          w_accept, w_last, w_issue;

  assign w_accept = r_ready & row_if.row_valid;
  assign w_last   = (r_rem == CW'(1));
  assign w_issue  = w_accept & (w_last | (w_cnt == PW'(PARALLEL_SIZE-1)));

  reduction_row_packer u_packer (
    .clk      (CLK_i),
    .rst_n    (RST_ni),
    .i_accept (w_accept),
    .i_issue  (w_issue),
    .i_row    (row_if.row),
    .o_cnt    (w_cnt),
    .o_group  (w_group)
  );

  // acc_rst resets high so the accumulator sits at zero through reset.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_seed    <= '0;
      r_operand <= '0;
      r_acc_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rv      <= 1'b0;
    end else begin
      r_operand <= w_issue ? w_group : '0;
      r_acc_rst <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_rem     <= num_rows_i;
          r_seed    <= seed_i;
          r_rv      <= 1'b0;
          r_acc_rst <= 1'b1;
          r_busy    <= 1'b1;
          r_state   <= S_CLEAR;
        end
        S_CLEAR: if (r_rem != '0) begin
          r_ready <= 1'b1;
          r_state <= S_ACCUM;
        end else begin
          r_state <= S_FLUSH;
        end
        S_ACCUM: if (w_accept) begin
          r_rem <= r_rem - 1'b1;
          if (w_last) begin
            r_ready <= 1'b0;
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_rv    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign row_if.row_ready = r_ready;
  assign operand_o        = r_operand;
  assign set_reg_o        = r_seed;
  assign acc_rst_o        = r_acc_rst;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign result_valid_o   = r_rv;
endmodule

// File: tb/tb_reduction_feeder.sv
// Scoreboard bench: directed jobs drive the feeder into a behavioural fp16 accumulator.
module tb_reduction_feeder;
  import reduction_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_rows = '0;
  row_t          seed = '0;
  group_t        operand;
  row_t          set_reg;
  logic          acc_rst, busy, done, rv;

  reduction_feeder_if rif ();

  reduction_feeder dut (
    .CLK_i          (clk),
    .RST_ni         (rst_n),
    .start_i        (start),
    .num_rows_i     (num_rows),
    .seed_i         (seed),
    .row_if         (rif),
    .operand_o      (operand),
    .set_reg_o      (set_reg),
    .acc_rst_o      (acc_rst),
    .busy_o         (busy),
    .done_o         (done),
    .result_valid_o (rv)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      m = real'(h[9:0]) / 16777216.0;
    end else begin
      m = 1.0 + real'(h[9:0]) / 1024.0;
      while (e > 15) begin m = m * 2.0; e--; end
      while (e < 15) begin m = m / 2.0; e++; end
    end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    int   e, f;
    real  m;
    s = (x < 0.0);
    m = s ? -x : x;
    if (m == 0.0) return {s, 15'h0};
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
    f = int'((m - 1.0) * 1024.0);
    return {s, 5'(e), 10'(f)};
  endfunction

  // Reduction unit model: held at set_reg while acc_rst, else adds all operand rows.
  real acc [TILE_SIZE];

  function automatic real lane_sum(input int i);
    real s;
    s = 0.0;
    for (int p = 0; p < PARALLEL_SIZE; p++) s = s + h2r(operand[p][i]);
    return s;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < TILE_SIZE; i++)
      acc[i] <= acc_rst ? h2r(set_reg[i]) : acc[i] + lane_sum(i);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          groups;
    int          done_edge;
    int          ready_cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: counts issued groups and ready cycles, checks everything at done_o.
  initial begin
    int   g_cnt, r_cnt, bad;
    exp_t e;
    g_cnt = 0;
    r_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        g_cnt = 0;
        r_cnt = 0;
      end else begin
        if (operand != '0) g_cnt++;
        if (rif.row_ready) r_cnt++;
        if (done) begin
          check("done_expected", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            bad = 0;
            for (int i = 0; i < TILE_SIZE; i++)
              if (r2h(acc[i]) != e.res) bad++;
            check("result_lane0", longint'(r2h(acc[0])), longint'(e.res));
            check("result_bad_lanes", bad, 0);
            check("groups_issued", g_cnt, e.groups);
            check("result_valid_at_done", longint'(rv), 1);
            if (e.done_edge >= 0) check("done_edge", cyc, e.done_edge);
            if (e.ready_cyc >= 0) check("ready_cycles", r_cnt, e.ready_cyc);
          end
          g_cnt = 0;
          r_cnt = 0;
        end
      end
    end
  end

  task automatic run_job(input int n, input logic [15:0] seedv, input logic [15:0] rowv,
                         input bit toggle, input bit push, input logic [15:0] res,
                         input int groups, input int ready_cyc, input bit ign, input int abort_at);
    int   sent, k, t;
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.res       = res;
      e.groups    = groups;
      e.done_edge = toggle ? -1 : cyc + n + 3;
      e.ready_cyc = ready_cyc;
      sb.push_back(e);
    end
    start    = 1'b1;
    num_rows = CW'(n);
    seed     = {TILE_SIZE{seedv}};
    @(negedge clk);
    start    = 1'b0;
    num_rows = CW'(7);
    seed     = {TILE_SIZE{16'h4900}};
    sent = 0; k = 0; t = 0;
    while (sent < n && t < 200) begin
      if (abort_at > 0 && sent == abort_at) break;
      rif.row_valid = toggle ? (k % 2 == 1) : 1'b1;
      rif.row       = {TILE_SIZE{rowv}};
      start         = ign && (k == 2);
      if (start) begin
        num_rows = CW'(5);
        seed     = {TILE_SIZE{16'h4500}};
      end
      if (rif.row_ready && rif.row_valid) sent++;
      @(negedge clk);
      k++; t++;
    end
    rif.row_valid = 1'b0;
    start         = 1'b0;
    if (t >= 200) check("row_accept_timeout", t, 0);
    if (abort_at > 0) return;
    t = 0;
    while (!done && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("done_timeout", t, 0);
    if (ign) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done_start", longint'(busy), 0);
      @(negedge clk);
      check("still_idle", longint'(busy), 0);
    end
    t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("busy_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    rif.row_valid = 1'b0;
    rif.row       = '0;
    repeat (3) @(negedge clk);
    check("rst_acc_rst", longint'(acc_rst), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_result_valid", longint'(rv), 0);
    check("rst_row_ready", longint'(rif.row_ready), 0);
    check("rst_operand_zero", longint'(operand == '0), 1);
    check("rst_set_reg_zero", longint'(set_reg == '0), 1);
    check("rst_model_acc", longint'(r2h(acc[0])), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("acc_rst_release", longint'(acc_rst), 0);

    run_job(3, 16'h0000, 16'h3C00, 0, 1, 16'h4200, 1, 3, 0, 0);
    run_job(4, 16'h4000, 16'h3C00, 0, 1, 16'h4600, 2, 4, 0, 0);
    run_job(0, 16'h4500, 16'h3C00, 0, 1, 16'h4500, 0, 0, 0, 0);
    run_job(6, 16'h0000, 16'h3800, 1, 1, 16'h4200, 2, -1, 0, 0);

    // Abort after two rows, then a clean job must not see the stale slots.
    run_job(3, 16'h0000, 16'h3C00, 0, 0, 16'h0000, 0, -1, 0, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_operand_zero", longint'(operand == '0), 1);
    check("midrst_acc_rst", longint'(acc_rst), 1);
    check("midrst_row_ready", longint'(rif.row_ready), 0);
    repeat (2) @(negedge clk);
    check("midrst_model_acc", longint'(r2h(acc[0])), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(3, 16'h0000, 16'h3C00, 0, 1, 16'h4200, 1, 3, 0, 0);

    run_job(3, 16'h0000, 16'h3C00, 0, 1, 16'h4200, 1, 3, 1, 0);

    t = 0;
    while (sb.size() > 0 && t < 100) begin @(negedge clk); t++; end
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reduction_feeder.md
# reduction_feeder

Upstream operand-packing stage for the tile reduction unit. Accepts one tile row (TILE_SIZE fp16 lanes) per handshake, packs rows into groups of PARALLEL_SIZE, and issues each group to the reduction's `operand_i` for exactly one cycle. It also drives the reduction's seed (`set_reg_i`) and accumulator-load reset (`RST_i`), and flags when `reduction_o` holds seed + Σ rows. This keeps the free-running accumulator from double-counting or absorbing stale operands.

## Interface
- TILE_SIZE, 129, lanes per row
- PARALLEL_SIZE, 3, rows per issued group
- WIDTH, fpnew_pkg::fp_width(FP16) = 16, lane width
- MAX_ROWS, 1023, largest row count per job; CW = $clog2(MAX_ROWS+1)

Ports:
- CLK_i  in  1  clock
- RST_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin job; sampled only in IDLE
- num_rows_i  in  CW  rows in job, latched on start
- seed_i  in  TILE_SIZE×WIDTH  initial accumulator value, latched on start
- row_valid_i  in  1  row_i valid
- row_ready_o  out  1  row accepted when valid&&ready
- row_i  in  TILE_SIZE×WIDTH  input row
- operand_o  out  PARALLEL_SIZE×TILE_SIZE×WIDTH  to reduction operand_i; [0] is the oldest row
- set_reg_o  out  TILE_SIZE×WIDTH  to reduction set_reg_i
- acc_rst_o  out  1  active-high; to reduction RST_i
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse; reduction_o final this cycle
- result_valid_o  out  1  held from done_o until next accepted start

## Operation
- States: IDLE, CLEAR, ACCUM, FLUSH, DONE.
- IDLE: row_ready_o=0, operand_o=0.
  - On start_i, latch num_rows_i into the remaining counter and seed_i into set_reg_o.
  - Clear result_valid_o and go to CLEAR.
- CLEAR (1 cycle): acc_rst_o=1, so the reduction loads set_reg_o.
  - Next state is ACCUM if N>0, else FLUSH.
- ACCUM: row_ready_o=1.
  - Each accepted row goes to slot[cnt], and cnt increments (0..PARALLEL_SIZE-1).
  - On acceptance of the slot PARALLEL_SIZE-1 row, or of the last row: register {row_i, held slots} into operand_o.
    - Unfilled slots are padded with 16'h0000.
    - cnt resets to 0.
  - If that row was the last one, go to FLUSH.
- operand_o is nonzero for exactly one cycle per issued group and is 0 in every other cycle, including IDLE, CLEAR and DONE.
- FLUSH (1 cycle): the final group (or zeros when N=0) is applied; the reduction's accumulator updates at the closing edge.
- DONE (1 cycle): done_o=1, result_valid_o set, then go to IDLE.
- row_valid_i low mid-group: slots and cnt hold; nothing is issued.
- start_i outside IDLE is ignored, including during DONE.
- Padding uses +0; it does not change nonzero sums.

## Timing
- Edge 0 is the edge that samples start_i.
- CLEAR occupies cycle 0–1. The first possible row acceptance is at edge 2.
- With row_valid_i held high: rows are accepted at edges 2..N+1, and done_o is high in cycle N+2..N+3.
  - Same formula for N=0 (done at edge 2).
- Throughput is 1 row/cycle; row_ready_o never drops inside ACCUM.
- Group issued at edge k: the accumulator includes it at edge k+1.
- Reset values:
  - state=IDLE; operand_o=0, set_reg_o=0.
  - acc_rst_o=1, so the reduction accumulator is cleared to 0 during reset; it deasserts at the first edge after RST_ni rises.
  - busy_o, done_o, result_valid_o, row_ready_o = 0; cnt and remaining = 0.
- Reset mid-job: everything is abandoned immediately (async). Partially filled slots are discarded, never issued.
- acc_rst_o is a flop output (glitch-free), since the reduction consumes it as an asynchronous reset.

## Structure
- Shared package reduction_pkg holds:
  - TILE_SIZE, PARALLEL_SIZE, WIDTH (derived via fpnew_pkg::fp_width(FP16)).
  - typedefs lane_t, row_t [TILE_SIZE-1:0] lane_t, group_t [PARALLEL_SIZE-1:0] row_t.
  - state enum feeder_state_e.
  - FP16_POS_ZERO = 16'h0000.
- One sub-module: reduction_row_packer, which holds the slot registers and cnt and produces the padded group on an issue strobe.
- The FSM, counters and control flops live in reduction_feeder.

## Test plan
- N=3, rows all 16'h3C00 (1.0), seed 0: one group nonzero for exactly 1 cycle, done_o at edge 5, every lane of reduction_o = 16'h4200 (3.0).
- N=4, rows 1.0, seed 16'h4000 (2.0): groups {r0,r1,r2} then {r3,0,0}; result 16'h4600 (6.0), done at edge 6.
- N=0, seed 16'h4500: row_ready_o never high, operand_o always 0, done at edge 2, result 16'h4500.
- N=6, rows 16'h3800 (0.5), row_valid_i toggling every cycle: operand_o nonzero exactly 2 cycles; result 16'h4200; no double counting.
- Assert RST_ni low after 2 rows accepted: during reset, acc_rst_o=1, reduction_o=0, busy_o=0, operand_o=0. A following N=3 job at 1.0 with seed 0 yields 3.0.
- start_i pulsed in ACCUM and in DONE: ignored; num_rows and seed are unchanged; a single done_o pulse occurs.
